// File: rtl/adder_pkg.sv
// Shared constants and FSM encodings for the chunked sequential adder.
package adder_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder, purely combinational.
module rca_16bit (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic w_c;

  // Ripple the carry bit by bit through a chain of full adders.
  always_comb begin
    sum = '0;
    w_c = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = in1[i] ^ in2[i] ^ w_c;
      w_c    = (in1[i] & in2[i]) | (w_c & (in1[i] ^ in2[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/seq_adder_64bit.sv
// Sequential multi-word adder: one 16-bit chunk per cycle through a single
// shared ripple-carry adder, carry held in a register between chunks.
module seq_adder_64bit
  import adder_pkg::*;
#(
  parameter int NCHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CHUNK_W*NCHUNK-1:0] in1,
  input  logic [CHUNK_W*NCHUNK-1:0] in2,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [CHUNK_W*NCHUNK-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W     = CHUNK_W * NCHUNK;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Two's-complement overflow: like-signed operands producing an unlike-signed result.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t             r_state;
  state_t             w_state_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_part;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK_W-1:0] w_chunk_a;
  logic [CHUNK_W-1:0] w_chunk_b;
  logic [CHUNK_W-1:0] w_chunk_sum;
  logic               w_chunk_cout;
  logic [W-1:0]       w_part_next;

  // A new operation may start from IDLE or straight out of DONE (back-to-back).
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

  assign w_chunk_a = r_a[int'(r_idx) * CHUNK_W +: CHUNK_W];
  assign w_chunk_b = r_b[int'(r_idx) * CHUNK_W +: CHUNK_W];

  rca_16bit u_rca (
    .in1  (w_chunk_a),
    .in2  (w_chunk_b),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_chunk_cout)
  );

  // Merge the freshly computed chunk into the partial sum.
  always_comb begin
    w_part_next = r_part;
    w_part_next[int'(r_idx) * CHUNK_W +: CHUNK_W] = w_chunk_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured outside ADD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ADD;
      ADD:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? ADD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in1;
      r_b     <= in2;
      r_carry <= cin;
      r_idx   <= '0;
      r_part  <= '0;
    end else if (r_state == ADD) begin
      r_part  <= w_part_next;
      r_carry <= w_chunk_cout;
      r_idx   <= r_idx + 1'b1;
      // Top-chunk carry goes only to cout; it never wraps into chunk 0.
      if (w_last) begin
        r_sum  <= w_part_next;
        r_cout <= w_chunk_cout;
        r_ovf  <= ovf_f(r_a[W-1], r_b[W-1], w_part_next[W-1]);
      end
    end
  end

  assign busy = (r_state == ADD);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
